// File: rtl/pagerank_gather_if.sv
// Streaming bus for the PageRank gather stage: a contribution input stream
// and a per-node rank output stream, each with its own valid/ready pair.
interface pagerank_gather_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_node_id;
  logic [63:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_node_id;
  logic [63:0] out_rank;

  modport master (
    output in_valid, in_node_id, in_value, out_ready,
    input  in_ready, out_valid, out_node_id, out_rank
  );

  modport slave (
    input  in_valid, in_node_id, in_value, out_ready,
    output in_ready, out_valid, out_node_id, out_rank
  );
endinterface

// File: rtl/pagerank_gather.sv
// PageRank gather stage: sums streamed contributions per node, applies the
// damping formula at end of iteration and emits new ranks in node order.
module pagerank_gather #(
  parameter int          NODES_IN_GRAPH = 32,
  parameter int          FRAC_BITS      = 32,
  parameter logic [63:0] DAMPING        = 64'd3650722202
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                gather_enable,
  input  logic                scatter_done,
  output logic                iteration_done,
  output logic                id_error,
  output logic                overrun,
  pagerank_gather_if.slave    bus
);

  localparam int          K_W    = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam int          PROD_W = 64 + FRAC_BITS;
  localparam logic [63:0] ONE    = 64'd1 << FRAC_BITS;
  localparam logic [63:0] BASE   = (ONE - DAMPING) / 64'(NODES_IN_GRAPH);
  localparam logic [K_W-1:0] LAST_K = K_W'(NODES_IN_GRAPH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_APPLY = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [63:0]    acc_q [NODES_IN_GRAPH];
  logic [63:0]    acc_d [NODES_IN_GRAPH];
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_node_id_q, out_node_id_d;
  logic [63:0]    out_rank_q, out_rank_d;
  logic           id_error_q, id_error_d;
  logic           overrun_q, overrun_d;

  logic [K_W-1:0]    acc_idx;
  logic              id_legal;
  logic [64:0]       acc_sum;
  logic [PROD_W-1:0] product;
  logic [64:0]       rank_sum;

  function automatic logic [63:0] sat64(input logic [64:0] s);
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  // Accumulation reads the registered sum each cycle, so repeated ids
  // chain naturally without a forwarding path.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    acc_d         = acc_q;
    out_valid_d   = out_valid_q;
    out_node_id_d = out_node_id_q;
    out_rank_d    = out_rank_q;
    id_error_d    = id_error_q;
    overrun_d     = overrun_q;

    acc_idx  = bus.in_node_id[K_W-1:0];
    id_legal = bus.in_node_id < 32'(NODES_IN_GRAPH);
    acc_sum  = {1'b0, acc_q[acc_idx]} + {1'b0, bus.in_value};
    product  = PROD_W'(DAMPING[FRAC_BITS-1:0]) * PROD_W'(acc_q[k_q]);
    rank_sum = {1'b0, BASE} + {1'b0, product[PROD_W-1:FRAC_BITS]};

    if (bus.in_valid && (state_q != ST_ACCUM))
      overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (gather_enable) begin
          state_d    = ST_ACCUM;
          id_error_d = 1'b0;
          overrun_d  = bus.in_valid;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          if (id_legal)
            acc_d[acc_idx] = sat64(acc_sum);
          else
            id_error_d = 1'b1;
        end
        if (scatter_done)
          state_d = ST_APPLY;
      end
      ST_APPLY: begin
        out_node_id_d = 32'(k_q);
        out_rank_d    = sat64(rank_sum);
        out_valid_d   = 1'b1;
        state_d       = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          acc_d[k_q]  = '0;
          out_valid_d = 1'b0;
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_APPLY;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      out_valid_q   <= 1'b0;
      out_node_id_q <= '0;
      out_rank_q    <= '0;
      id_error_q    <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NODES_IN_GRAPH; i++)
        acc_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      out_valid_q   <= out_valid_d;
      out_node_id_q <= out_node_id_d;
      out_rank_q    <= out_rank_d;
      id_error_q    <= id_error_d;
      overrun_q     <= overrun_d;
      for (int i = 0; i < NODES_IN_GRAPH; i++)
        acc_q[i] <= acc_d[i];
    end
  end

  assign bus.in_ready    = (state_q == ST_ACCUM);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_node_id = out_node_id_q;
  assign bus.out_rank    = out_rank_q;
  assign iteration_done  = (state_q == ST_DONE);
  assign id_error        = id_error_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_pagerank_gather.sv
// Directed bench for pagerank_gather (4 nodes): expected ranks are pushed to a
// scoreboard at scatter_done and popped as the DUT emits them.
module tb_pagerank_gather;

  localparam int          N     = 4;
  localparam logic [63:0] D     = 64'hD999_999A;
  localparam logic [63:0] BASE  = 64'h0999_9999;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [31:0] id;
    logic [63:0] rank;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic gather_enable = 1'b0;
  logic scatter_done = 1'b0;
  logic iteration_done, id_error, overrun;

  pagerank_gather_if bus();

  pagerank_gather #(
    .NODES_IN_GRAPH (N),
    .FRAC_BITS      (32),
    .DAMPING        (D)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .gather_enable  (gather_enable),
    .scatter_done   (scatter_done),
    .iteration_done (iteration_done),
    .id_error       (id_error),
    .overrun        (overrun),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] model_acc [N];
  bit          model_accum = 0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] modelRank(input logic [63:0] a);
    logic [95:0] p;
    logic [64:0] s;
    p = 96'(D) * 96'(a);
    s = {1'b0, BASE} + {1'b0, p[95:32]};
    return s[64] ? ONES : s[63:0];
  endfunction

  function automatic void modelAdd(input logic [31:0] id, input logic [63:0] v);
    logic [64:0] s;
    if (model_accum && id < N) begin
      s = {1'b0, model_acc[id[1:0]]} + {1'b0, v};
      model_acc[id[1:0]] = s[64] ? ONES : s[63:0];
    end
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < N; i++) model_acc[i] = '0;
    model_accum = 0;
    sb.delete();
  endfunction

  task automatic startIteration();
    gather_enable = 1'b1;
    @(negedge clock);
    gather_enable = 1'b0;
    model_accum = 1;
  endtask

  task automatic applyStimulus(input logic [31:0] id, input logic [63:0] v);
    bus.in_valid   = 1'b1;
    bus.in_node_id = id;
    bus.in_value   = v;
    @(negedge clock);
    bus.in_valid   = 1'b0;
    modelAdd(id, v);
  endtask

  task automatic endScatter(input bit with_input, input logic [31:0] id, input logic [63:0] v);
    scatter_done   = 1'b1;
    bus.in_valid   = with_input;
    bus.in_node_id = id;
    bus.in_value   = v;
    @(negedge clock);
    scatter_done   = 1'b0;
    bus.in_valid   = 1'b0;
    if (with_input) modelAdd(id, v);
    for (int i = 0; i < N; i++) begin
      sb.push_back('{id: 32'(i), rank: modelRank(model_acc[i])});
      model_acc[i] = '0;
    end
    model_accum = 0;
  endtask

  task automatic waitValid(output bit ok);
    int waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    ok = (bus.out_valid === 1'b1);
  endtask

  task automatic drainIteration(input int nodes, input int stall_node, input int stall_cycles);
    bit   ok;
    exp_t e;
    for (int n = 0; n < nodes; n++) begin
      waitValid(ok);
      if (!ok) begin
        checkOutput("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        return;
      end
      e = sb.pop_front();
      if (n == stall_node) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clock);
          checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
          checkOutput("stall_id", 64'(bus.out_node_id), 64'(e.id));
          checkOutput("stall_rank", bus.out_rank, e.rank);
        end
      end
      checkOutput("node_id", 64'(bus.out_node_id), 64'(e.id));
      checkOutput("rank", bus.out_rank, e.rank);
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      checkOutput("valid_drop", 64'(bus.out_valid), 64'd0);
    end
    if (nodes == N) begin
      checkOutput("iteration_done", 64'(iteration_done), 64'd1);
      @(negedge clock);
      checkOutput("iteration_done_pulse", 64'(iteration_done), 64'd0);
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    end
  endtask

  initial begin
    bit ok;
    bus.in_valid    = 1'b0;
    bus.in_node_id  = '0;
    bus.in_value    = '0;
    bus.out_ready   = 1'b0;
    modelClear();

    // Reset values
    repeat (3) @(negedge clock);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_rank", bus.out_rank, 64'd0);
    checkOutput("rst_out_node_id", 64'(bus.out_node_id), 64'd0);
    checkOutput("rst_iteration_done", 64'(iteration_done), 64'd0);
    checkOutput("rst_id_error", 64'(id_error), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Back-to-back accumulation into node 2, stall on node 1
    $display("[TB] basic accumulation with output stall");
    startIteration();
    checkOutput("in_ready_accum", 64'(bus.in_ready), 64'd1);
    applyStimulus(2, 64'h1_0000_0000);
    applyStimulus(2, 64'h8000_0000);
    applyStimulus(2, 64'h8000_0000);
    endScatter(0, 0, 0);
    checkOutput("latency_early", 64'(bus.out_valid), 64'd0);
    @(negedge clock);
    checkOutput("latency_rise", 64'(bus.out_valid), 64'd1);
    drainIteration(N, 1, 3);

    // Second iteration: accumulators must start from zero
    $display("[TB] second iteration");
    startIteration();
    applyStimulus(3, 64'h4000_0000);
    endScatter(0, 0, 0);
    drainIteration(N, -1, 0);

    // Illegal node id
    $display("[TB] illegal node id");
    startIteration();
    applyStimulus(7, 64'd5);
    checkOutput("id_error_set", 64'(id_error), 64'd1);
    endScatter(0, 0, 0);
    drainIteration(N, -1, 0);
    checkOutput("id_error_sticky", 64'(id_error), 64'd1);

    // Saturating accumulation on node 0
    $display("[TB] saturation");
    startIteration();
    checkOutput("id_error_cleared", 64'(id_error), 64'd0);
    applyStimulus(0, ONES);
    applyStimulus(0, ONES);
    endScatter(0, 0, 0);
    checkOutput("sat_expected", sb[0].rank, 64'hD999_999A_0999_9998);
    drainIteration(N, -1, 0);

    // Contribution in the same cycle as scatter_done
    $display("[TB] input coincident with scatter_done");
    startIteration();
    endScatter(1, 1, 64'h1_0000_0000);
    checkOutput("same_cycle_expected", sb[1].rank, 64'hE333_3333);
    drainIteration(N, -1, 0);

    // Overrun while idle, then reset during emission
    $display("[TB] overrun and mid-iteration reset");
    applyStimulus(0, 64'd1);
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    startIteration();
    checkOutput("overrun_cleared", 64'(overrun), 64'd0);
    applyStimulus(1, 64'h2000_0000);
    applyStimulus(3, 64'h1_0000_0000);
    endScatter(0, 0, 0);
    drainIteration(2, -1, 0);
    waitValid(ok);
    checkOutput("pre_reset_node", 64'(bus.out_node_id), 64'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_out_rank", bus.out_rank, 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
    modelClear();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    startIteration();
    endScatter(0, 0, 0);
    drainIteration(N, -1, 0);
    checkOutput("overrun_after_reset", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
